touch_grid_capture: RTL and testbench

- Converts the raw touch-panel coordinate stream from the ADC SPI controller (12-bit x/y plus a new-coordinate strobe) into a GRID_ROWS x GRID_COLS binary drawing bitmap.
- The recognition logic reads the bitmap as one row word per row.
- Before plotting, the block averages groups of samples and can apply a plus-shaped brush. It detects end-of-stroke by inactivity timeout and signals it with a done pulse.
- Generalised successor to the fixed 12x8 grid path: grid size, coordinate mapping, averaging depth, timeout and clear mode are all parameters.

---
 rtl/touch_grid_capture.sv | 249 ++++++++++++++++++++++++
 tb/tb_touch_grid_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/touch_grid_capture.sv
// touch_grid_capture
//   Turns the raw touch-panel coordinate stream (x/y plus a one-cycle
//   new-coordinate strobe) into a GRID_ROWS x GRID_COLS binary bitmap.
//   Samples are averaged in groups of 2^AVG_LOG2. Each group average is
//   mapped to a cell and plotted, either as a single cell or as a plus-shaped
//   brush. A stroke ends after TIMEOUT idle cycles, which is flagged with a
//   one-cycle oDONE pulse.
//
// Ports
//   iCLK        system clock
//   iRST        synchronous active-high reset
//   iX_COORD    raw x coordinate, valid while iNEW_COORD=1
//   iY_COORD    raw y coordinate, valid while iNEW_COORD=1
//   iNEW_COORD  one-cycle sample strobe
//   iCLEAR      synchronous grid and state clear
//   iBRUSH      0 = single cell, 1 = plus (centre and 4 neighbours)
//   oGRID       bitmap; row r = [r*GRID_COLS +: GRID_COLS], column c = bit c
//   oDONE       one-cycle end-of-stroke pulse
//   oBUSY       high while a stroke is in progress (ACTIVE or PLOT)
//   oPLOT_CNT   points plotted since the last clear, saturating
//   oLAST_COL   column of the last in-range plotted point
//   oLAST_ROW   row of the last in-range plotted point
module touch_grid_capture #(
    parameter int unsigned COORD_W    = 12,
    parameter int unsigned GRID_COLS  = 8,
    parameter int unsigned GRID_ROWS  = 12,
    parameter int unsigned X_OFFSET   = 256,
    parameter int unsigned X_SHIFT    = 8,
    parameter int unsigned Y_OFFSET   = 256,
    parameter int unsigned Y_SHIFT    = 8,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned TIMEOUT    = 12500000,
    parameter int unsigned AUTO_CLEAR = 1
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic [COORD_W-1:0]             iX_COORD,
    input  logic [COORD_W-1:0]             iY_COORD,
    input  logic                           iNEW_COORD,
    input  logic                           iCLEAR,
    input  logic                           iBRUSH,
    output logic [GRID_ROWS*GRID_COLS-1:0] oGRID,
    output logic                           oDONE,
    output logic                           oBUSY,
    output logic [15:0]                    oPLOT_CNT,
    output logic [7:0]                     oLAST_COL,
    output logic [7:0]                     oLAST_ROW
);

    localparam int unsigned SUM_W   = COORD_W + AVG_LOG2;
    localparam int unsigned CNT_W   = AVG_LOG2 + 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CELLS   = GRID_ROWS * GRID_COLS;

    localparam logic [CNT_W-1:0]   GROUP      = CNT_W'(1 << AVG_LOG2);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        PLOT,
        DONE,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [SUM_W-1:0]   sum_x;
    logic [SUM_W-1:0]   sum_y;
    logic [CNT_W-1:0]   count;
    logic [TIMER_W-1:0] timer;
    logic [CELLS-1:0]   grid;
    logic [15:0]        plot_cnt;
    logic [7:0]         last_col;
    logic [7:0]         last_row;

    // FSM strobes to the datapath
    logic accept;      // add sample to the running group
    logic seed;        // sample during PLOT starts the next group
    logic do_plot;     // write the finished group into the grid
    logic discard;     // stroke timed out, drop the partial group
    logic auto_clr;    // first sample of a new stroke wipes the bitmap
    logic timer_inc;

    logic group_full;

    // Group average and cell mapping, all widened to 32 bits so that the
    // offset subtraction and range tests never wrap in a narrow type.
    logic [31:0] avg_x;
    logic [31:0] avg_y;
    logic [31:0] col;
    logic [31:0] row;
    logic        x_ok;
    logic        y_ok;
    logic        in_range;
    logic [CELLS-1:0] mask;

    // ------------------------------------------------------------------
    // Mapping and brush mask
    // ------------------------------------------------------------------
    assign group_full = (count + 1'b1) == GROUP;

    assign avg_x = 32'(COORD_W'(sum_x >> AVG_LOG2));
    assign avg_y = 32'(COORD_W'(sum_y >> AVG_LOG2));
    assign col   = (avg_x - X_OFFSET) >> X_SHIFT;
    assign row   = (avg_y - Y_OFFSET) >> Y_SHIFT;
    assign x_ok  = (avg_x >= X_OFFSET) && (col < GRID_COLS);
    assign y_ok  = (avg_y >= Y_OFFSET) && (row < GRID_ROWS);
    assign in_range = x_ok && y_ok;

    // Scanning only real cells clips brush neighbours that fall off the
    // grid without any explicit underflow or overflow checks.
    always_comb begin
        mask = '0;
        for (int unsigned r = 0; r < GRID_ROWS; r++) begin
            for (int unsigned c = 0; c < GRID_COLS; c++) begin
                mask[r*GRID_COLS + c] =
                    ((r == row) && (c == col)) ||
                    (iBRUSH && (((r == row) && ((c + 1 == col) || (c == col + 1))) ||
                                ((c == col) && ((r + 1 == row) || (r == row + 1)))));
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST || iCLEAR) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        seed       = 1'b0;
        do_plot    = 1'b0;
        discard    = 1'b0;
        auto_clr   = 1'b0;
        timer_inc  = 1'b0;

        case (state)
            IDLE: begin
                if (iNEW_COORD) begin
                    accept     = 1'b1;
                    state_next = group_full ? PLOT : ACTIVE;
                end
            end
            ACTIVE: begin
                if (iNEW_COORD) begin
                    accept     = 1'b1;
                    state_next = group_full ? PLOT : ACTIVE;
                end else if (timer == TIMER_LAST) begin
                    discard    = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_inc  = 1'b1;
                end
            end
            PLOT: begin
                do_plot = 1'b1;
                if (iNEW_COORD) begin
                    seed = 1'b1;
                    // A seeded group of one is already complete.
                    state_next = (GROUP == CNT_W'(1)) ? PLOT : ACTIVE;
                end else begin
                    state_next = ACTIVE;
                end
            end
            DONE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (iNEW_COORD) begin
                    accept     = 1'b1;
                    auto_clr   = (AUTO_CLEAR != 0);
                    state_next = group_full ? PLOT : ACTIVE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST || iCLEAR) begin
            grid     <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            count    <= '0;
            timer    <= '0;
            plot_cnt <= '0;
            last_col <= '0;
            last_row <= '0;
        end else begin
            if (do_plot && in_range) begin
                grid     <= grid | mask;
                last_col <= col[7:0];
                last_row <= row[7:0];
                if (plot_cnt != 16'hFFFF) begin
                    plot_cnt <= plot_cnt + 16'd1;
                end
            end

            if (auto_clr) begin
                grid     <= '0;
                plot_cnt <= '0;
                last_col <= '0;
                last_row <= '0;
            end

            if (accept) begin
                sum_x <= sum_x + SUM_W'(iX_COORD);
                sum_y <= sum_y + SUM_W'(iY_COORD);
                count <= count + 1'b1;
            end else if (seed) begin
                sum_x <= SUM_W'(iX_COORD);
                sum_y <= SUM_W'(iY_COORD);
                count <= CNT_W'(1);
            end else if (do_plot || discard) begin
                sum_x <= '0;
                sum_y <= '0;
                count <= '0;
            end

            if (accept || seed || discard) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign oGRID     = grid;
    assign oDONE     = (state == DONE);
    assign oBUSY     = (state == ACTIVE) || (state == PLOT);
    assign oPLOT_CNT = plot_cnt;
    assign oLAST_COL = last_col;
    assign oLAST_ROW = last_row;

endmodule

// File: tb/tb_touch_grid_capture.sv
// Directed bench for touch_grid_capture with an 8-column x 12-row grid,
// offsets 256, shifts 8, groups of four samples and a 100-cycle timeout.
module tb_touch_grid_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] x_coord = '0;
    logic [11:0] y_coord = '0;
    logic        new_coord = 1'b0;
    logic        clear = 1'b0;
    logic        brush = 1'b0;
    logic [95:0] grid;
    logic        done;
    logic        busy;
    logic [15:0] plot_cnt;
    logic [7:0]  last_col;
    logic [7:0]  last_row;

    int checks = 0;
    int errors = 0;

    touch_grid_capture #(
        .COORD_W   (12),
        .GRID_COLS (8),
        .GRID_ROWS (12),
        .X_OFFSET  (256),
        .X_SHIFT   (8),
        .Y_OFFSET  (256),
        .Y_SHIFT   (8),
        .AVG_LOG2  (2),
        .TIMEOUT   (100),
        .AUTO_CLEAR(1)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iX_COORD  (x_coord),
        .iY_COORD  (y_coord),
        .iNEW_COORD(new_coord),
        .iCLEAR    (clear),
        .iBRUSH    (brush),
        .oGRID     (grid),
        .oDONE     (done),
        .oBUSY     (busy),
        .oPLOT_CNT (plot_cnt),
        .oLAST_COL (last_col),
        .oLAST_ROW (last_row)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [11:0] x, input logic [11:0] y);
        x_coord   = x;
        y_coord   = y;
        new_coord = 1'b1;
        tick();
        new_coord = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [95:0] bit34;
    logic [95:0] brush_corner;
    int          early;
    int          done_at;
    int          done_cycles;

    initial begin
        bit34        = 96'd1 << 34;
        brush_corner = 96'h103;

        // 1. Reset held for two cycles, then released
        tick();
        tick();
        check("rst_grid", grid, '0);
        check("rst_done", 96'(done), '0);
        check("rst_busy", 96'(busy), '0);
        check("rst_plot_cnt", 96'(plot_cnt), '0);
        rst = 1'b0;
        tick();
        check("idle_grid", grid, '0);
        check("idle_busy", 96'(busy), '0);
        check("idle_done", 96'(done), '0);

        // 2. Four samples at (0x300,0x500) -> row 4, col 2, bit 34
        brush = 1'b0;
        repeat (4) sample(12'h300, 12'h500);
        check("t2_latency_grid", grid, '0);
        tick();
        check("t2_grid", grid, bit34);
        check("t2_plot_cnt", 96'(plot_cnt), 96'd1);
        check("t2_last_col", 96'(last_col), 96'd2);
        check("t2_last_row", 96'(last_row), 96'd4);
        check("t2_busy", 96'(busy), 96'd1);

        do_clear();
        check("clr_grid", grid, '0);
        check("clr_plot_cnt", 96'(plot_cnt), '0);
        check("clr_busy", 96'(busy), '0);

        // 3. Plus brush at the corner cell: negative neighbours clipped
        brush = 1'b1;
        repeat (4) sample(12'h100, 12'h100);
        tick();
        check("t3_grid", grid, brush_corner);
        check("t3_plot_cnt", 96'(plot_cnt), 96'd1);
        check("t3_last_col", 96'(last_col), 96'd0);
        check("t3_last_row", 96'(last_row), 96'd0);
        brush = 1'b0;

        // 4. Seven samples then idle: second group discarded
        do_clear();
        repeat (7) sample(12'h300, 12'h500);
        early = 0;
        for (int i = 1; i < 100; i++) begin
            tick();
            if (done !== 1'b0) early++;
        end
        check("t4_no_early_done", 96'(early), '0);
        tick();
        check("t4_done_pulse", 96'(done), 96'd1);
        check("t4_done_busy", 96'(busy), '0);
        tick();
        check("t4_done_one_cycle", 96'(done), '0);
        check("t4_hold_busy", 96'(busy), '0);
        check("t4_plot_cnt", 96'(plot_cnt), 96'd1);
        check("t4_grid", grid, bit34);

        // 5. Out-of-range groups: x below offset, then column 8
        do_clear();
        repeat (4) sample(12'h080, 12'h200);
        repeat (4) sample(12'h900, 12'h200);
        tick();
        check("t5_grid", grid, '0);
        check("t5_plot_cnt", 96'(plot_cnt), '0);
        done_at = 0;
        for (int i = 2; i <= 110; i++) begin
            tick();
            if (done === 1'b1 && done_at == 0) done_at = i;
        end
        check("t5_done_time", 96'((done_at >= 100) && (done_at <= 101)), 96'd1);
        check("t5_plot_cnt_end", 96'(plot_cnt), '0);

        // 6. Clear coincident with a sample drops that sample
        repeat (4) sample(12'h300, 12'h500);
        tick();
        check("t6_pre_grid", grid, bit34);
        clear = 1'b1;
        sample(12'h100, 12'h100);
        clear = 1'b0;
        check("t6_clr_grid", grid, '0);
        check("t6_clr_busy", 96'(busy), '0);
        check("t6_clr_plot_cnt", 96'(plot_cnt), '0);
        repeat (3) sample(12'h100, 12'h100);
        tick();
        tick();
        check("t6_dropped_sample", grid, '0);
        check("t6_active_busy", 96'(busy), 96'd1);
        sample(12'h100, 12'h100);
        tick();
        check("t6_plot_grid", grid, 96'd1);
        check("t6_plot_cnt", 96'(plot_cnt), 96'd1);

        // Stroke ends; a sample in DONE is dropped, one in HOLD auto-clears
        done_cycles = 0;
        for (int i = 0; i < 150 && done !== 1'b1; i++) tick();
        check("t6_stroke_done", 96'(done), 96'd1);
        sample(12'h300, 12'h500);
        check("t6_hold_busy", 96'(busy), '0);
        check("t6_hold_grid", grid, 96'd1);
        sample(12'h300, 12'h500);
        check("t6_autoclr_grid", grid, '0);
        check("t6_autoclr_plot_cnt", 96'(plot_cnt), '0);
        check("t6_autoclr_last_col", 96'(last_col), '0);
        check("t6_autoclr_busy", 96'(busy), 96'd1);
        repeat (2) sample(12'h300, 12'h500);
        tick();
        check("t6_done_sample_dropped", grid, '0);
        sample(12'h300, 12'h500);
        tick();
        check("t6_new_stroke_grid", grid, bit34);
        check("t6_new_stroke_cnt", 96'(plot_cnt), 96'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
